// File: rtl/seq6_code_checker.sv
// Receive-side checker for the six-state code sequence 0,1,3,4,5,7: decodes each sample,
// checks it against the legal successor, tracks lock with hysteresis and counts errors.
module seq6_code_checker #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             code_valid,
    input  logic [2:0]       code,
    output logic             locked,
    output logic [2:0]       index,
    output logic [2:0]       expected,
    output logic             illegal_code,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT + 1)   : 1;
    localparam int BW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;

    typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;

    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            3'd0:    succ = 3'd1;
            3'd1:    succ = 3'd3;
            3'd3:    succ = 3'd4;
            3'd4:    succ = 3'd5;
            3'd5:    succ = 3'd7;
            default: succ = 3'd0;  // 7 wraps to 0; 2 and 6 never reach prev
        endcase
    endfunction

    function automatic logic [2:0] decode(input logic [2:0] c);
        case (c)
            3'd0:    decode = 3'd0;
            3'd1:    decode = 3'd1;
            3'd3:    decode = 3'd2;
            3'd4:    decode = 3'd3;
            3'd5:    decode = 3'd4;
            3'd7:    decode = 3'd5;
            default: decode = 3'd7;
        endcase
    endfunction

    state_t           state_q;
    logic [2:0]       prev_q;
    logic [GW-1:0]    good_cnt_q;
    logic [BW-1:0]    bad_cnt_q;
    logic             locked_q;
    logic [2:0]       index_q;
    logic [2:0]       expected_q;
    logic             illegal_q;
    logic             seq_err_q;
    logic [ERR_W-1:0] err_count_q;

    logic [2:0]       code_idx;
    logic             code_legal;
    logic [2:0]       code_succ;
    logic [2:0]       prev_succ;
    logic [2:0]       prev_succ2;
    logic             match;
    logic [GW-1:0]    good_inc;
    logic [BW-1:0]    bad_inc;
    logic             seq_err_d;
    logic [ERR_W-1:0] err_count_d;

    assign code_idx    = decode(code);
    assign code_legal  = (code_idx != 3'd7);
    assign code_succ   = succ(code);
    assign prev_succ   = succ(prev_q);
    assign prev_succ2  = succ(prev_succ);
    assign match       = (code == prev_succ);
    assign good_inc    = good_cnt_q + GW'(1);
    assign bad_inc     = bad_cnt_q + BW'(1);

    // Any sample outside HUNT that is not the legal successor is a sequencing error.
    assign seq_err_d   = code_valid && (state_q != HUNT) && !(code_legal && match);
    assign err_count_d = (seq_err_d && (err_count_q != '1)) ? err_count_q + ERR_W'(1)
                                                             : err_count_q;

    // NOTE: non-blocking assignments only, so every branch reads the pre-edge register values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            locked_q    <= 1'b0;
            index_q     <= '0;
            expected_q  <= '0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            illegal_q   <= code_valid && !code_legal;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
            if (code_valid) begin
                index_q <= code_idx;
                unique case (state_q)
                    HUNT: begin
                        if (code_legal) begin
                            prev_q     <= code;
                            expected_q <= code_succ;
                            good_cnt_q <= '0;
                            state_q    <= ACQ;
                        end else begin
                            expected_q <= prev_succ;
                        end
                    end
                    ACQ: begin
                        if (!code_legal) begin
                            state_q    <= HUNT;
                            good_cnt_q <= '0;
                            expected_q <= prev_succ;
                        end else begin
                            prev_q     <= code;
                            expected_q <= code_succ;
                            if (!match) begin
                                good_cnt_q <= '0;
                            end else if (good_inc == GW'(LOCK_CNT)) begin
                                state_q    <= LOCK;
                                locked_q   <= 1'b1;
                                good_cnt_q <= '0;
                                bad_cnt_q  <= '0;
                            end else begin
                                good_cnt_q <= good_inc;
                            end
                        end
                    end
                    LOCK: begin
                        if (code_legal && match) begin
                            bad_cnt_q  <= '0;
                            prev_q     <= code;
                            expected_q <= code_succ;
                        end else begin
                            // An illegal word flywheels prev forward so one glitch costs one sample.
                            if (code_legal) begin
                                prev_q     <= code;
                                expected_q <= code_succ;
                            end else begin
                                prev_q     <= prev_succ;
                                expected_q <= prev_succ2;
                            end
                            if (bad_inc == BW'(UNLOCK_CNT)) begin
                                state_q   <= HUNT;
                                locked_q  <= 1'b0;
                                bad_cnt_q <= '0;
                            end else begin
                                bad_cnt_q <= bad_inc;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign locked       = locked_q;
    assign index        = index_q;
    assign expected     = expected_q;
    assign illegal_code = illegal_q;
    assign seq_err      = seq_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_seq6_code_checker.sv
// Directed bench for seq6_code_checker: default instance plus a LOCK_CNT=1,
// UNLOCK_CNT=1, ERR_W=2 instance for the single-step and saturation corners.
module tb_seq6_code_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       cv, cv2;
    logic [2:0] cd, cd2;

    logic       locked, ill, serr;
    logic [2:0] index, expected;
    logic [7:0] err;

    logic       locked2, ill2, serr2;
    logic [2:0] index2, expected2;
    logic [1:0] err2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq6_code_checker dut (
        .clk(clk), .rst(rst), .code_valid(cv), .code(cd),
        .locked(locked), .index(index), .expected(expected),
        .illegal_code(ill), .seq_err(serr), .err_count(err)
    );

    seq6_code_checker #(.LOCK_CNT(1), .UNLOCK_CNT(1), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .code_valid(cv2), .code(cd2),
        .locked(locked2), .index(index2), .expected(expected2),
        .illegal_code(ill2), .seq_err(serr2), .err_count(err2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] c);
        cv = v;
        cd = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [2:0] c);
        cv2 = 1'b1;
        cd2 = c;
        @(posedge clk);
        #1;
        cv2 = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cv  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cv = 1'b0; cd = 3'd0; cv2 = 1'b0; cd2 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 8'(locked), 8'd0);
        chk("rst_index", 8'(index), 8'd0);
        chk("rst_expected", 8'(expected), 8'd0);
        chk("rst_illegal", 8'(ill), 8'd0);
        chk("rst_seq_err", 8'(serr), 8'd0);
        chk("rst_err_count", err, 8'd0);
        chk("rst_err_count2", 8'(err2), 8'd0);
        rst = 1'b0;

        // Clean sequence through the 7->0 wrap; lock after third correct transition.
        step(1, 3'd0); chk("t1_idx0", 8'(index), 8'd0); chk("t1_exp0", 8'(expected), 8'd1);
        step(1, 3'd1); chk("t1_idx1", 8'(index), 8'd1); chk("t1_exp1", 8'(expected), 8'd3);
        step(1, 3'd3); chk("t1_idx3", 8'(index), 8'd2); chk("t1_lock3", 8'(locked), 8'd0);
        step(1, 3'd4); chk("t1_idx4", 8'(index), 8'd3); chk("t1_lock4", 8'(locked), 8'd1);
        chk("t1_exp4", 8'(expected), 8'd5);
        step(1, 3'd5); chk("t1_idx5", 8'(index), 8'd4);
        step(1, 3'd7); chk("t1_idx7", 8'(index), 8'd5); chk("t1_exp7", 8'(expected), 8'd0);
        step(1, 3'd0); chk("t1_wrap_idx", 8'(index), 8'd0); chk("t1_wrap_serr", 8'(serr), 8'd0);
        step(1, 3'd1); chk("t1_idx1b", 8'(index), 8'd1); chk("t1_err", err, 8'd0);
        chk("t1_locked", 8'(locked), 8'd1);

        // Illegal 2 in place of 3: flywheel keeps the following 4 aligned.
        step(1, 3'd2);
        chk("t2_ill", 8'(ill), 8'd1); chk("t2_serr", 8'(serr), 8'd1);
        chk("t2_idx", 8'(index), 8'd7); chk("t2_exp", 8'(expected), 8'd4);
        chk("t2_lock", 8'(locked), 8'd1); chk("t2_err", err, 8'd1);
        step(1, 3'd4);
        chk("t2_ill_clr", 8'(ill), 8'd0); chk("t2_serr_clr", 8'(serr), 8'd0);
        chk("t2_idx4", 8'(index), 8'd3); chk("t2_lock4", 8'(locked), 8'd1);
        step(1, 3'd5); chk("t2_lock5", 8'(locked), 8'd1); chk("t2_err5", err, 8'd1);

        // Fresh lock, then two consecutive mismatches drop lock.
        pulse_reset();
        chk("t3_err_rst", err, 8'd0);
        step(1, 3'd0); step(1, 3'd1); step(1, 3'd3); step(1, 3'd4);
        chk("t3_relock", 8'(locked), 8'd1);
        step(1, 3'd5); step(1, 3'd7); step(1, 3'd0); step(1, 3'd1);
        chk("t3_pre_lock", 8'(locked), 8'd1); chk("t3_pre_err", err, 8'd0);
        step(1, 3'd5);
        chk("t3_mm1_serr", 8'(serr), 8'd1); chk("t3_mm1_lock", 8'(locked), 8'd1);
        chk("t3_mm1_exp", 8'(expected), 8'd7); chk("t3_mm1_err", err, 8'd1);
        step(1, 3'd4);
        chk("t3_mm2_serr", 8'(serr), 8'd1); chk("t3_mm2_lock", 8'(locked), 8'd0);
        chk("t3_mm2_err", err, 8'd2); chk("t3_mm2_idx", 8'(index), 8'd3);
        step(1, 3'd6);
        chk("t3_hunt_ill", 8'(ill), 8'd1); chk("t3_hunt_serr", 8'(serr), 8'd0);
        chk("t3_hunt_err", err, 8'd2);

        // Relock from HUNT, then a six-cycle gap with code wiggling.
        step(1, 3'd0); step(1, 3'd1); step(1, 3'd3);
        chk("t4_acq_lock", 8'(locked), 8'd0);
        step(1, 3'd4);
        chk("t4_lock", 8'(locked), 8'd1); chk("t4_err", err, 8'd2);
        for (int i = 0; i < 6; i++) begin
            step(0, 3'($urandom_range(0, 7)));
            chk("t4_gap_ill", 8'(ill), 8'd0); chk("t4_gap_serr", 8'(serr), 8'd0);
            chk("t4_gap_lock", 8'(locked), 8'd1); chk("t4_gap_idx", 8'(index), 8'd3);
            chk("t4_gap_exp", 8'(expected), 8'd5); chk("t4_gap_err", err, 8'd2);
        end
        step(1, 3'd5);
        chk("t4_resume_lock", 8'(locked), 8'd1); chk("t4_resume_serr", 8'(serr), 8'd0);
        chk("t4_resume_idx", 8'(index), 8'd4); chk("t4_resume_exp", 8'(expected), 8'd7);

        // Reset while locked with err_count=2; the valid sample in that cycle is dropped.
        rst = 1'b1;
        step(1, 3'd7);
        rst = 1'b0;
        chk("t6_lock", 8'(locked), 8'd0); chk("t6_err", err, 8'd0);
        chk("t6_exp", 8'(expected), 8'd0); chk("t6_idx", 8'(index), 8'd0);
        chk("t6_serr", 8'(serr), 8'd0);
        step(1, 3'd0); step(1, 3'd1); step(1, 3'd3);
        chk("t6_acq", 8'(locked), 8'd0);
        step(1, 3'd4);
        chk("t6_relock", 8'(locked), 8'd1); chk("t6_relock_err", err, 8'd0);

        // Illegal word in ACQ falls back to HUNT, so acquisition restarts from the next word.
        pulse_reset();
        step(1, 3'd0);
        step(1, 3'd2);
        chk("acq_ill", 8'(ill), 8'd1); chk("acq_ill_serr", 8'(serr), 8'd1);
        chk("acq_ill_err", err, 8'd1); chk("acq_ill_idx", 8'(index), 8'd7);
        step(1, 3'd1);
        chk("acq_anchor_serr", 8'(serr), 8'd0); chk("acq_anchor_exp", 8'(expected), 8'd3);
        step(1, 3'd3); step(1, 3'd4);
        chk("acq_two_good", 8'(locked), 8'd0);
        step(1, 3'd5);
        chk("acq_three_good", 8'(locked), 8'd1); chk("acq_err_hold", err, 8'd1);
        cv = 1'b0;

        // Narrow instance: saturation at 3, lock on first match, unlock on first bad sample.
        step2(3'd0);
        chk("n_anchor_serr", 8'(serr2), 8'd0); chk("n_anchor_err", 8'(err2), 8'd0);
        step2(3'd5); chk("n_err1", 8'(err2), 8'd1); chk("n_serr1", 8'(serr2), 8'd1);
        step2(3'd0); chk("n_err2", 8'(err2), 8'd2);
        step2(3'd5); chk("n_err3", 8'(err2), 8'd3);
        step2(3'd0); chk("n_sat4", 8'(err2), 8'd3); chk("n_serr4", 8'(serr2), 8'd1);
        step2(3'd5); chk("n_sat5", 8'(err2), 8'd3); chk("n_serr5", 8'(serr2), 8'd1);
        chk("n_no_lock", 8'(locked2), 8'd0);
        step2(3'd7);
        chk("n_lock1", 8'(locked2), 8'd1); chk("n_lock1_serr", 8'(serr2), 8'd0);
        step2(3'd2);
        chk("n_unlock_ill", 8'(ill2), 8'd1); chk("n_unlock_serr", 8'(serr2), 8'd1);
        chk("n_unlock", 8'(locked2), 8'd0); chk("n_unlock_err", 8'(err2), 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
